opkt_rr_arbiter: RTL and testbench

OPKT_RR_ARBITER -- requirements
Module: opkt_rr_arbiter

---
 rtl/opkt_rr_arbiter.sv | 83 ++++++++
 tb/tb_opkt_rr_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opkt_rr_arbiter.sv
// rtl/opkt_rr_arbiter.sv - round-robin merge of SpiNNaker packet sources into one registered output
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   ipkt_data         NUM_SRC packets of 72 bits, source k at [72k+71:72k]
//   ipkt_vld/rdy      per-source handshake; transfer when vld & rdy
//   src_en            per-source enable; a disabled source is never granted
//   opkt_data/vld/rdy merged registered output towards the output mapper
//   last_grant        index of the most recently granted source
//   cnt_clr           synchronous clear of fwd_cnt
//   fwd_cnt           saturating count of output handshakes

module opkt_rr_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int IDX_W   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SRC*72-1:0]   ipkt_data,
   input  logic [NUM_SRC-1:0]      ipkt_vld,
   output logic [NUM_SRC-1:0]      ipkt_rdy,
   input  logic [NUM_SRC-1:0]      src_en,
   output logic [71:0]             opkt_data,
   output logic                    opkt_vld,
   input  logic                    opkt_rdy,
   output logic [IDX_W-1:0]        last_grant,
   input  logic                    cnt_clr,
   output logic [31:0]             fwd_cnt
);

   logic [NUM_SRC-1:0] req;
   logic               slot_free;
   logic               gnt_any;
   logic [IDX_W-1:0]   gnt_idx;
   logic               grant;
   int                 cand;

   assign req       = ipkt_vld & src_en;
   // The single output slot can take a new packet when it is empty or is
   // being emptied by the downstream handshake in this same cycle.
   assign slot_free = !opkt_vld || opkt_rdy;

   // Rotating priority: search upward from the source after the last grant,
   // wrapping, so the last winner has lowest priority next time.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         cand = (int'(last_grant) + i) % NUM_SRC;
         if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = IDX_W'(cand);
         end
      end
   end

   // Reset gating keeps every source stalled while rst is held.
   assign grant    = !rst && slot_free && gnt_any;
   assign ipkt_rdy = grant ? (NUM_SRC'(1) << gnt_idx) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         opkt_vld   <= 1'b0;
         last_grant <= IDX_W'(NUM_SRC - 1);
      end else if (grant) begin
         opkt_data  <= ipkt_data[int'(gnt_idx)*72 +: 72];
         opkt_vld   <= 1'b1;
         last_grant <= gnt_idx;
      end else if (opkt_rdy) begin
         opkt_vld   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         fwd_cnt <= '0;
      end else if (opkt_vld && opkt_rdy && fwd_cnt != 32'hFFFF_FFFF) begin
         fwd_cnt <= fwd_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_opkt_rr_arbiter.sv
// tb/tb_opkt_rr_arbiter.sv - self-checking bench for opkt_rr_arbiter

module tb_opkt_rr_arbiter;

   localparam int NUM_SRC = 4;
   localparam int IDX_W   = 2;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_SRC*72-1:0] ipkt_data;
   logic [NUM_SRC-1:0]    ipkt_vld;
   logic [NUM_SRC-1:0]    ipkt_rdy;
   logic [NUM_SRC-1:0]    src_en;
   logic [71:0]           opkt_data;
   logic                  opkt_vld;
   logic                  opkt_rdy;
   logic [IDX_W-1:0]      last_grant;
   logic                  cnt_clr;
   logic [31:0]           fwd_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [71:0] sb_q[$];
   logic        m_vld;
   int          m_last;
   logic [31:0] m_cnt;

   opkt_rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .ipkt_data  (ipkt_data),
      .ipkt_vld   (ipkt_vld),
      .ipkt_rdy   (ipkt_rdy),
      .src_en     (src_en),
      .opkt_data  (opkt_data),
      .opkt_vld   (opkt_vld),
      .opkt_rdy   (opkt_rdy),
      .last_grant (last_grant),
      .cnt_clr    (cnt_clr),
      .fwd_cnt    (fwd_cnt)
   );

   always #5 clk = ~clk;

   // Scoreboard: every output handshake must deliver the oldest expected packet.
   always @(negedge clk) begin
      if (!rst && opkt_vld && opkt_rdy) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got packet %h, required none", opkt_data);
         end else begin
            logic [71:0] exp_pkt;
            exp_pkt = sb_q.pop_front();
            if (opkt_data !== exp_pkt) begin
               errors++;
               $display("FAIL sb_data: got %h, required %h", opkt_data, exp_pkt);
            end
         end
      end
   end

   function automatic int model_pick(input logic [NUM_SRC-1:0] r, input int last);
      for (int i = 1; i <= NUM_SRC; i++) begin
         int k;
         k = (last + i) % NUM_SRC;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [NUM_SRC-1:0] onehot(input int g);
      logic [NUM_SRC-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   task automatic rand_data();
      for (int i = 0; i < NUM_SRC*72/32; i++) ipkt_data[i*32 +: 32] = $urandom;
   endtask

   // One clock: samples ipkt_rdy at the falling edge, advances the model, and
   // returns with inputs free to change 1 time unit after the rising edge.
   task automatic advance(output int g, output logic [NUM_SRC-1:0] rdy_seen);
      logic [NUM_SRC-1:0] r;
      logic free;
      @(negedge clk);
      rdy_seen = ipkt_rdy;
      r    = ipkt_vld & src_en;
      free = !m_vld || opkt_rdy;
      g    = (!rst && free) ? model_pick(r, m_last) : -1;
      if (rst) begin
         m_vld  = 1'b0;
         m_last = NUM_SRC - 1;
         m_cnt  = '0;
         sb_q.delete();
      end else begin
         if (cnt_clr) m_cnt = '0;
         else if (m_vld && opkt_rdy && m_cnt != CNT_MAX) m_cnt = m_cnt + 32'd1;
         if (g >= 0) begin
            sb_q.push_back(ipkt_data[g*72 +: 72]);
            m_vld  = 1'b1;
            m_last = g;
         end else if (opkt_rdy) begin
            m_vld = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int g;
      logic [NUM_SRC-1:0] rs;
      ipkt_vld = '0;
      opkt_rdy = 1'b1;
      cnt_clr  = 1'b0;
      repeat (2) advance(g, rs);
   endtask

   task automatic test_reset();
      int g;
      logic [NUM_SRC-1:0] rs;
      rst = 1'b1; ipkt_vld = '1; src_en = '1; opkt_rdy = 1'b1; cnt_clr = 1'b0;
      rand_data();
      for (int c = 0; c < 2; c++) begin
         advance(g, rs);
         checks++;
         if (rs !== '0) begin
            errors++; $display("FAIL reset_ipkt_rdy: got %b, required 0000", rs);
         end
      end
      checks++;
      if (opkt_vld !== 1'b0) begin
         errors++; $display("FAIL reset_opkt_vld: got %b, required 0", opkt_vld);
      end
      checks++;
      if (last_grant !== 2'd3) begin
         errors++; $display("FAIL reset_last_grant: got %0d, required 3", last_grant);
      end
      checks++;
      if (fwd_cnt !== 32'd0) begin
         errors++; $display("FAIL reset_fwd_cnt: got %0d, required 0", fwd_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_round_robin();
      int g;
      logic [NUM_SRC-1:0] rs;
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      ipkt_vld = '1; src_en = '1; opkt_rdy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         rand_data();
         advance(g, rs);
         checks++;
         if (rs !== onehot(exp_seq[c]) || g != exp_seq[c]) begin
            errors++; $display("FAIL rr_grant[%0d]: got %b, required %b", c, rs, onehot(exp_seq[c]));
         end
         if (c == 0) begin
            checks++;
            if (opkt_vld !== 1'b1) begin
               errors++; $display("FAIL rr_latency: opkt_vld got %b, required 1", opkt_vld);
            end
         end
      end
      checks++;
      if (fwd_cnt !== 32'd4) begin
         errors++; $display("FAIL rr_fwd_cnt: got %0d, required 4", fwd_cnt);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int g;
      logic [NUM_SRC-1:0] rs;
      logic [71:0] held;
      cnt_clr = 1'b1;
      advance(g, rs);
      cnt_clr = 1'b0;
      ipkt_vld = 4'b0100; src_en = '1; opkt_rdy = 1'b0;
      rand_data();
      held = ipkt_data[2*72 +: 72];
      advance(g, rs);
      checks++;
      if (rs !== 4'b0100) begin
         errors++; $display("FAIL bp_grant: got %b, required 0100", rs);
      end
      for (int c = 0; c < 3; c++) begin
         rand_data();
         advance(g, rs);
         checks++;
         if (rs !== '0) begin
            errors++; $display("FAIL bp_stall_rdy[%0d]: got %b, required 0000", c, rs);
         end
         checks++;
         if (opkt_vld !== 1'b1 || opkt_data !== held) begin
            errors++; $display("FAIL bp_hold[%0d]: got %b/%h, required 1/%h", c, opkt_vld, opkt_data, held);
         end
      end
      ipkt_vld = '0; opkt_rdy = 1'b1;
      advance(g, rs);
      checks++;
      if (fwd_cnt !== 32'd1) begin
         errors++; $display("FAIL bp_fwd_cnt: got %0d, required 1", fwd_cnt);
      end
      drain();
   endtask

   task automatic test_src_en();
      int g;
      logic [NUM_SRC-1:0] rs;
      ipkt_vld = '1; src_en = 4'b1010; opkt_rdy = 1'b1;
      for (int c = 0; c < 6; c++) begin
         rand_data();
         advance(g, rs);
         checks++;
         if ((rs & 4'b0101) !== '0 || rs !== onehot(g) || !(g == 1 || g == 3)) begin
            errors++; $display("FAIL en_grant[%0d]: got %b, required %b", c, rs, onehot(g));
         end
      end
      // A packet already accepted must still leave after its source is disabled.
      opkt_rdy = 1'b0;
      rand_data();
      advance(g, rs);
      src_en = '0; opkt_rdy = 1'b1;
      advance(g, rs);
      checks++;
      if (rs !== '0 || opkt_vld !== 1'b0) begin
         errors++; $display("FAIL en_drop: rdy/vld got %b/%b, required 0000/0", rs, opkt_vld);
      end
      src_en = '1;
      drain();
   endtask

   task automatic test_wrap();
      int g;
      logic [NUM_SRC-1:0] rs;
      ipkt_vld = 4'b1000; src_en = '1; opkt_rdy = 1'b1;
      rand_data();
      advance(g, rs);
      checks++;
      if (last_grant !== 2'd3) begin
         errors++; $display("FAIL wrap_setup: last_grant got %0d, required 3", last_grant);
      end
      ipkt_vld = 4'b0110;
      rand_data();
      advance(g, rs);
      checks++;
      if (rs !== 4'b0010 || last_grant !== 2'd1) begin
         errors++; $display("FAIL wrap_first: got %b/%0d, required 0010/1", rs, last_grant);
      end
      rand_data();
      advance(g, rs);
      checks++;
      if (rs !== 4'b0100 || last_grant !== 2'd2) begin
         errors++; $display("FAIL wrap_second: got %b/%0d, required 0100/2", rs, last_grant);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int g;
      logic [NUM_SRC-1:0] rs;
      for (int c = 0; c < 300; c++) begin
         ipkt_vld = NUM_SRC'($urandom);
         src_en   = NUM_SRC'($urandom | $urandom);
         opkt_rdy = ($urandom_range(0, 3) != 0);
         cnt_clr  = ($urandom_range(0, 31) == 0);
         rand_data();
         advance(g, rs);
         checks++;
         if (rs !== onehot(g)) begin
            errors++; $display("FAIL b2b_rdy[%0d]: got %b, required %b", c, rs, onehot(g));
         end
         checks++;
         if (int'(last_grant) != m_last || opkt_vld !== m_vld || fwd_cnt !== m_cnt) begin
            errors++;
            $display("FAIL b2b_state[%0d]: got lg=%0d vld=%b cnt=%0d, required lg=%0d vld=%b cnt=%0d",
                     c, last_grant, opkt_vld, fwd_cnt, m_last, m_vld, m_cnt);
         end
      end
      drain();
   endtask

   task automatic test_saturation();
      int g;
      logic [NUM_SRC-1:0] rs;
      ipkt_vld = '1; src_en = '1; opkt_rdy = 1'b1; cnt_clr = 1'b0;
      force dut.fwd_cnt = 32'hFFFF_FFFD;
      #1;
      release dut.fwd_cnt;
      m_cnt = 32'hFFFF_FFFD;
      for (int c = 0; c < 5; c++) begin
         rand_data();
         advance(g, rs);
      end
      checks++;
      if (fwd_cnt !== CNT_MAX || m_cnt !== CNT_MAX) begin
         errors++; $display("FAIL sat_hold: got %h, required ffffffff", fwd_cnt);
      end
      cnt_clr = 1'b1;
      rand_data();
      advance(g, rs);
      cnt_clr = 1'b0;
      checks++;
      if (fwd_cnt !== 32'd0) begin
         errors++; $display("FAIL sat_clr_priority: got %0d, required 0", fwd_cnt);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      int g;
      logic [NUM_SRC-1:0] rs;
      ipkt_vld = '1; src_en = '1; opkt_rdy = 1'b0;
      rand_data();
      advance(g, rs);
      rst = 1'b1;
      advance(g, rs);
      checks++;
      if (opkt_vld !== 1'b0 || last_grant !== 2'd3 || fwd_cnt !== 32'd0 || rs !== '0) begin
         errors++;
         $display("FAIL rstmid_state: got vld=%b lg=%0d cnt=%0d rdy=%b, required 0/3/0/0000",
                  opkt_vld, last_grant, fwd_cnt, rs);
      end
      rst = 1'b0; ipkt_vld = 4'b0001; opkt_rdy = 1'b1;
      rand_data();
      advance(g, rs);
      checks++;
      if (rs !== 4'b0001) begin
         errors++; $display("FAIL rstmid_first_grant: got %b, required 0001", rs);
      end
      drain();
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
      end
   endtask

   initial begin
      rst = 1'b1; ipkt_vld = '0; src_en = '0; opkt_rdy = 1'b0; cnt_clr = 1'b0;
      ipkt_data = '0;
      m_vld = 1'b0; m_last = NUM_SRC - 1; m_cnt = '0;
      test_reset();
      test_round_robin();
      test_backpressure();
      test_src_en();
      test_wrap();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
